seq_booth_multiplier: RTL and testbench

Parametrised sequential multiplier, successor to the fixed 32-bit shift-add CompMultiplier. It adds WIDTH generalisation, per-operation signed/unsigned mode (radix-2 Booth), an optional early-exit path and an iteration count output. It keeps the Run/Ready handshake the existing multiplier benches drive, so it drops into the same test flow.

---
 rtl/mul_pkg.sv | 15 +
 rtl/booth_step.sv | 30 +++
 rtl/seq_booth_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_booth_multiplier.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the iteration counter: it must hold WIDTH+1.
    function automatic int CNT_W(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M according to {Q[0],q_-1},
// then arithmetic-right-shift the {A,Q,q_-1} register pair by one.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH:0]   q,
    input  logic             q_m1,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] a_next,
    output logic [WIDTH:0]   q_next,
    output logic             q_m1_next
);

    logic [WIDTH+1:0] sum;

    // Booth recode of the current bit pair, then shift in A's sign bit.
    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b10:   sum = a - m;
            2'b01:   sum = a + m;
            default: sum = a;
        endcase
        {a_next, q_next, q_m1_next} = {sum[WIDTH+1], sum, q};
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Parametrised sequential radix-2 Booth multiplier with Run/Ready handshake,
// signed/unsigned operation and optional early termination.
module seq_booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic                       Run,
    input  logic                       Signed,
    input  logic [WIDTH-1:0]           Multiplicand,
    input  logic [WIDTH-1:0]           Multiplier,
    output logic [2*WIDTH-1:0]         Product,
    output logic                       Ready,
    output logic                       Busy,
    output logic [CNT_W(WIDTH)-1:0]    Cycles
);

    localparam int            CW        = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH + 1);

    state_t           state;
    logic [WIDTH+1:0] a_reg;
    logic [WIDTH+1:0] m_reg;
    logic [WIDTH:0]   q_reg;
    logic             q_m1_reg;
    logic [CW-1:0]    iter_cnt;

    logic [WIDTH+1:0] a_next;
    logic [WIDTH:0]   q_next;
    logic             q_m1_next;
    logic [CW-1:0]    iter_next;
    logic [CW-1:0]    remaining;
    logic             tail_match;
    logic             finish_now;
    logic [2*WIDTH-1:0] product_next;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // Early-exit detect: once every unconsumed multiplier bit equals the
    // last consumed one, all remaining Booth pairs are no-ops and only the
    // shifts are left, which the bulk shifter performs in one go.
    always_comb begin
        iter_next  = iter_cnt + CW'(1);
        remaining  = LAST_ITER - iter_next;
        tail_match = 1'b1;
        for (int j = 0; j <= WIDTH; j++) begin
            if ((j < int'(remaining)) && (q_next[j] != q_m1_next)) begin
                tail_match = 1'b0;
            end
        end
        finish_now   = (iter_next == LAST_ITER) || ((EARLY_EXIT != 0) && tail_match);
        product_next = (2*WIDTH)'($unsigned($signed({a_next, q_next}) >>> remaining));
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            q_m1_reg <= 1'b0;
            iter_cnt <= '0;
            Product  <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            Cycles   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        m_reg    <= {{2{Signed & Multiplicand[WIDTH-1]}}, Multiplicand};
                        q_reg    <= {Signed & Multiplier[WIDTH-1], Multiplier};
                        a_reg    <= '0;
                        q_m1_reg <= 1'b0;
                        iter_cnt <= '0;
                        Busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_reg    <= a_next;
                    q_reg    <= q_next;
                    q_m1_reg <= q_m1_next;
                    iter_cnt <= iter_next;
                    if (finish_now) begin
                        Product <= product_next;
                        Cycles  <= iter_next;
                        Busy    <= 1'b0;
                        Ready   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        Ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench: a full-run and an early-exit instance share stimulus;
// expectations come from plain integer arithmetic and the early-exit rule.
module tb_seq_booth_multiplier;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 2);

    typedef struct {
        logic [2*W-1:0] prod;
        int             cycles;
        int             start;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           run = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;

    logic [2*W-1:0] prod_full, prod_early;
    logic           ready_full, ready_early;
    logic           busy_full, busy_early;
    logic [CW-1:0]  cycles_full, cycles_early;

    exp_t q_full[$];
    exp_t q_early[$];
    exp_t e_full, e_early;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic prev_rf = 1'b0;
    logic prev_re = 1'b0;

    seq_booth_multiplier #(.WIDTH(W), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .Reset_n(reset_n), .Run(run), .Signed(signed_mode),
        .Multiplicand(mcand), .Multiplier(mplier),
        .Product(prod_full), .Ready(ready_full), .Busy(busy_full), .Cycles(cycles_full)
    );

    seq_booth_multiplier #(.WIDTH(W), .EARLY_EXIT(1)) dut_early (
        .clk(clk), .Reset_n(reset_n), .Run(run), .Signed(signed_mode),
        .Multiplicand(mcand), .Multiplier(mplier),
        .Product(prod_early), .Ready(ready_early), .Busy(busy_early), .Cycles(cycles_early)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Mathematical product of the operands interpreted per mode.
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        return pa * pb;
    endfunction

    // Iterations used: first i where every not-yet-consumed bit of the
    // extended multiplier equals the last consumed bit (full run: W+1).
    function automatic int ref_iters(input logic [W-1:0] b, input logic s, input bit early);
        logic [W:0] ext;
        bit same;
        ext = {s & b[W-1], b};
        if (!early) return W + 1;
        for (int i = 1; i <= W; i++) begin
            same = 1'b1;
            for (int k = i; k <= W; k++) begin
                if (ext[k] != ext[i-1]) same = 1'b0;
            end
            if (same) return i;
        end
        return W + 1;
    endfunction

    // Monitor: on each rising Ready, pop and compare product, count, latency.
    always @(negedge clk) begin
        if (ready_full && !prev_rf) begin
            if (q_full.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL full_unexpected_ready: got Ready=1, expected no pending operation");
            end else begin
                e_full = q_full.pop_front();
                check_output("full_product", prod_full, e_full.prod);
                check_output("full_cycles", 64'(cycles_full), 64'(e_full.cycles));
                check_output("full_latency", 64'(cyc - e_full.start), 64'(e_full.cycles));
            end
        end
        if (ready_early && !prev_re) begin
            if (q_early.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL early_unexpected_ready: got Ready=1, expected no pending operation");
            end else begin
                e_early = q_early.pop_front();
                check_output("early_product", prod_early, e_early.prod);
                check_output("early_cycles", 64'(cycles_early), 64'(e_early.cycles));
                check_output("early_latency", 64'(cyc - e_early.start), 64'(e_early.cycles));
            end
        end
        prev_rf = ready_full;
        prev_re = ready_early;
    end

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        mcand       = a;
        mplier      = b;
        signed_mode = s;
        run         = 1'b1;
        q_full.push_back('{ref_product(a, b, s), ref_iters(b, s, 1'b0), cyc + 1});
        q_early.push_back('{ref_product(a, b, s), ref_iters(b, s, 1'b1), cyc + 1});
    endtask

    task automatic wait_done(input bit need_early, input bit check_busy);
        int busy_seen;
        bit done;
        busy_seen = 0;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (busy_full) busy_seen++;
            if (ready_full && (ready_early || !need_early)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got no Ready within 200 cycles, expected Ready");
        end else if (check_busy) begin
            check_output("busy_cycles", 64'(busy_seen), 64'(W + 1));
        end
    endtask

    task automatic release_run();
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check_output("ready_drop_full", 64'(ready_full), 64'd0);
        check_output("ready_drop_early", 64'(ready_early), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        apply_stimulus(a, b, s);
        wait_done(1'b1, 1'b1);
        release_run();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check_output("reset_product", prod_full, 64'd0);
        check_output("reset_ready", 64'(ready_full), 64'd0);
        check_output("reset_busy", 64'(busy_full), 64'd0);
        check_output("reset_cycles", 64'(cycles_early), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_output("ff_x_ff_unsigned", prod_full, 64'hFFFF_FFFE_0000_0001);
        check_output("ff_x_ff_cycles", 64'(cycles_full), 64'd33);

        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        check_output("neg3_x_7_signed", prod_full, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_output("min_x_neg1_signed", prod_early, 64'h0000_0000_8000_0000);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_output("min_x_max_unsigned", prod_full, 64'h7FFF_FFFF_8000_0000);

        run_op(32'd5, 32'd3, 1'b0);
        check_output("early_5x3_product", prod_early, 64'd15);
        check_output("early_5x3_cycles", 64'(cycles_early), 64'd3);
        run_op(32'd9, 32'd0, 1'b0);
        check_output("early_9x0_product", prod_early, 64'd0);
        check_output("early_9x0_cycles", 64'(cycles_early), 64'd1);

        // Asynchronous reset 10 cycles into CALC
        apply_stimulus(32'hFFFF_FFFF, 32'h1234_5677, 1'b0);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("abort_product", prod_full, 64'd0);
        check_output("abort_ready", 64'(ready_full), 64'd0);
        check_output("abort_busy", 64'(busy_full), 64'd0);
        check_output("abort_early_product", prod_early, 64'd0);
        run = 1'b0;
        q_full.delete();
        q_early.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // 6 x 7 after reset, then Run held high in DONE
        apply_stimulus(32'd6, 32'd7, 1'b0);
        wait_done(1'b1, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_output("hold_ready", 64'(ready_full), 64'd1);
            check_output("hold_busy", 64'(busy_full), 64'd0);
            check_output("hold_early_ready", 64'(ready_early), 64'd1);
        end
        release_run();
        check_output("hold_product_after_release", prod_full, 64'd42);

        // Run dropped mid-CALC: single-cycle Ready pulse
        apply_stimulus(32'h1234_5678, 32'h8765_4321, 1'b1);
        repeat (5) @(negedge clk);
        run = 1'b0;
        wait_done(1'b0, 1'b0);
        @(negedge clk);
        check_output("pulse_ready_low", 64'(ready_full), 64'd0);

        // Random sweep, mixing full-range and small-magnitude multipliers
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                rb = W'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                rb = $urandom;
            end
            apply_stimulus(ra, rb, rs);
            wait_done(1'b1, 1'b1);
            @(negedge clk);
            run = 1'b0;
            @(negedge clk);
        end

        check_output("full_queue_drained", 64'(q_full.size()), 64'd0);
        check_output("early_queue_drained", 64'(q_early.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
